// File: rtl/fetch_arbiter.sv
// Round-robin fetch scheduler for the wavefront pool.
// Keeps a PC and an active bit per wavefront slot, grants one eligible slot at a
// time, issues a single outstanding instruction-memory fetch and forwards the
// returned word to the instruction buffer while advancing that slot's PC.
module fetch_arbiter #(
  parameter int NUM_WF = 40,
  parameter int WFID_W = 6,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dispatch_valid,
  input  logic [WFID_W-1:0] dispatch_wfid,
  input  logic [PC_W-1:0]   dispatch_pc,
  input  logic [NUM_WF-1:0] wf_ready,
  input  logic              redirect_valid,
  input  logic [WFID_W-1:0] redirect_wfid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_valid,
  input  logic [WFID_W-1:0] halt_wfid,
  output logic              fetch_req_valid,
  output logic [WFID_W-1:0] fetch_req_wfid,
  output logic [PC_W-1:0]   fetch_req_pc,
  input  logic              mem_ack,
  input  logic [31:0]       mem_instr,
  output logic              buff_wr,
  output logic [WFID_W-1:0] buff_wfid,
  output logic [31:0]       buff_instr,
  output logic [PC_W-1:0]   buff_pc,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  localparam logic [WFID_W-1:0] LAST_WF = WFID_W'(NUM_WF - 1);

  state_e              state_q;
  logic [NUM_WF-1:0]   active_q;
  logic [PC_W-1:0]     pc_q [NUM_WF];
  logic [WFID_W-1:0]   rr_ptr_q;
  logic [WFID_W-1:0]   grant_wfid_q;
  logic [PC_W-1:0]     grant_pc_q;
  logic                squash_q;

  logic                redirect_ok;
  logic                halt_ok;
  logic                dispatch_ok;
  logic [NUM_WF-1:0]   eligible;
  logic                hi_found;
  logic                lo_found;
  logic [WFID_W-1:0]   hi_wfid;
  logic [WFID_W-1:0]   lo_wfid;
  logic                pick_found;
  logic [WFID_W-1:0]   pick_wfid;
  logic                hit_grant;
  logic                hit_pick;
  logic                squash_d;

  // Out-of-range slot ids are dropped so they can never touch the table.
  assign redirect_ok = redirect_valid && (redirect_wfid <= LAST_WF);
  assign halt_ok     = halt_valid && (halt_wfid <= LAST_WF);
  assign dispatch_ok = dispatch_valid && (dispatch_wfid <= LAST_WF);

  assign eligible = active_q & wf_ready;

  // Lowest eligible slot at/after rr_ptr wins, otherwise the lowest one below it (wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_wfid  = '0;
    lo_wfid  = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (WFID_W'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_wfid  = WFID_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_wfid  = WFID_W'(i);
        end
      end
    end
  end

  assign pick_found = hi_found | lo_found;
  assign pick_wfid  = hi_found ? hi_wfid : lo_wfid;

  // Any table write to the slot owning the fetch makes its returned word stale.
  assign hit_grant = (redirect_ok && (redirect_wfid == grant_wfid_q)) ||
                     (halt_ok     && (halt_wfid     == grant_wfid_q)) ||
                     (dispatch_ok && (dispatch_wfid == grant_wfid_q));
  assign hit_pick  = (redirect_ok && (redirect_wfid == pick_wfid)) ||
                     (halt_ok     && (halt_wfid     == pick_wfid)) ||
                     (dispatch_ok && (dispatch_wfid == pick_wfid));
  assign squash_d  = squash_q | hit_grant;

  // FSM, registered outputs and slot table; later table writes override earlier ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      active_q        <= '0;
      for (int i = 0; i < NUM_WF; i++) pc_q[i] <= '0;
      rr_ptr_q        <= '0;
      grant_wfid_q    <= '0;
      grant_pc_q      <= '0;
      squash_q        <= 1'b0;
      fetch_req_valid <= 1'b0;
      fetch_req_wfid  <= '0;
      fetch_req_pc    <= '0;
      buff_wr         <= 1'b0;
      buff_wfid       <= '0;
      buff_instr      <= '0;
      buff_pc         <= '0;
      busy            <= 1'b0;
    end else begin
      fetch_req_valid <= 1'b0;
      fetch_req_wfid  <= '0;
      fetch_req_pc    <= '0;
      buff_wr         <= 1'b0;
      buff_wfid       <= '0;
      buff_instr      <= '0;
      buff_pc         <= '0;

      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_wfid_q    <= pick_wfid;
            grant_pc_q      <= pc_q[pick_wfid];
            rr_ptr_q        <= (pick_wfid == LAST_WF) ? '0 : pick_wfid + WFID_W'(1);
            squash_q        <= hit_pick;
            fetch_req_valid <= 1'b1;
            fetch_req_wfid  <= pick_wfid;
            fetch_req_pc    <= pc_q[pick_wfid];
            busy            <= 1'b1;
            state_q         <= ST_REQ;
          end
        end
        ST_REQ: begin
          squash_q <= squash_d;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          squash_q <= squash_d;
          if (mem_ack) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            if (!squash_d) begin
              buff_wr                <= 1'b1;
              buff_wfid              <= grant_wfid_q;
              buff_instr             <= mem_instr;
              buff_pc                <= grant_pc_q;
              pc_q[grant_wfid_q]     <= grant_pc_q + PC_W'(4);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase

      if (redirect_ok) pc_q[redirect_wfid] <= redirect_pc;
      if (halt_ok) active_q[halt_wfid] <= 1'b0;
      if (dispatch_ok) begin
        active_q[dispatch_wfid] <= 1'b1;
        pc_q[dispatch_wfid]     <= dispatch_pc;
      end
    end
  end

endmodule
